// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch request bus between the PC generator and the fetch unit
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid_o;
  logic            fetch_ready_i;
  logic [XLEN-1:0] pc_o;

  // PC generator side: drives the request, observes acceptance
  modport master (
    output fetch_valid_o,
    output pc_o,
    input  fetch_ready_i
  );

  // Fetch unit side: observes the request, drives acceptance
  modport slave (
    input  fetch_valid_o,
    input  pc_o,
    output fetch_ready_i
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with fetch handshake and buffered redirects
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter int              STEP       = 4,
  parameter logic [XLEN-1:0] START_ADDR = 32'h0000_0000,
  parameter logic [XLEN-1:0] END_ADDR   = 32'h0000_3FFC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_flag_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            ex_branch_flag_i,
  input  logic [XLEN-1:0] ex_branch_addr_i,
  input  logic            stalled_i,
  pc_gen_if.master        fetch,
  output logic            misalign_o,
  output logic            redirect_pend_o
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            misalign_q;

  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] tgt_aligned;
  logic [XLEN-1:0] pc_next_seq;
  logic            req;
  logic            xfer;

  // Trap outranks branch; targets are forced onto a fetch boundary
  assign req         = trap_flag_i | ex_branch_flag_i;
  assign tgt         = trap_flag_i ? trap_addr_i : ex_branch_addr_i;
  assign tgt_aligned = tgt & ~LOW_MASK;
  assign xfer        = valid_q & fetch.fetch_ready_i;
  // Sequential advance wraps to the window start once the last slot has been fetched
  assign pc_next_seq = (pc_q >= END_ADDR) ? START_ADDR : (pc_q + XLEN'(STEP));

  // State and request registers; reset drops any in-flight request and buffered redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= START_ADDR;
      pend_q     <= START_ADDR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      misalign_q <= req & (|(tgt & LOW_MASK));
    end
  end

  // Next-state: redirects win over stall; pc only moves on an accepted or absent request
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
        if (req) pc_d = tgt_aligned;
      end
      RUN: begin
        if (req && (xfer || !valid_q)) begin
          pc_d = tgt_aligned;
        end else if (req) begin
          pend_d  = tgt_aligned;
          state_d = PEND;
        end else if (xfer && !stalled_i) begin
          pc_d = pc_next_seq;
        end
      end
      PEND: begin
        // The newest redirect replaces the buffered one, even in the accepting cycle
        if (req) pend_d = tgt_aligned;
        if (xfer) begin
          pc_d    = req ? tgt_aligned : pend_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign fetch.pc_o          = pc_q;
  assign fetch.fetch_valid_o = valid_q;
  assign misalign_o          = misalign_q;
  assign redirect_pend_o     = (state_q == PEND);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        trap_flag_i;
  logic [31:0] trap_addr_i;
  logic        ex_branch_flag_i;
  logic [31:0] ex_branch_addr_i;
  logic        stalled_i;
  logic        misalign_o;
  logic        redirect_pend_o;

  pc_gen_if #(.XLEN(32)) fif ();

  pc_gen #(
    .XLEN(32), .STEP(4), .START_ADDR(32'h0000_0000), .END_ADDR(32'h0000_3FFC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .trap_flag_i      (trap_flag_i),
    .trap_addr_i      (trap_addr_i),
    .ex_branch_flag_i (ex_branch_flag_i),
    .ex_branch_addr_i (ex_branch_addr_i),
    .stalled_i        (stalled_i),
    .fetch            (fif.master),
    .misalign_o       (misalign_o),
    .redirect_pend_o  (redirect_pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        trap;
    logic [31:0] taddr;
    logic        br;
    logic [31:0] baddr;
    logic        stall;
    logic        ready;
    logic [31:0] e_pc;
    logic        e_val;
    logic        e_pend;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        val;
    logic        pend;
    logic        mis;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic trap, input logic [31:0] taddr,
                              input logic br, input logic [31:0] baddr,
                              input logic stall, input logic ready,
                              input logic [31:0] e_pc, input logic e_val,
                              input logic e_pend, input logic e_mis);
    vec_t v;
    v.trap = trap; v.taddr = taddr; v.br = br; v.baddr = baddr;
    v.stall = stall; v.ready = ready;
    v.e_pc = e_pc; v.e_val = e_val; v.e_pend = e_pend; v.e_mis = e_mis;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Caller sits at a negedge; drive, record expectation, sample 1ns after the edge, return at next negedge
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    trap_flag_i       = v.trap;
    trap_addr_i       = v.taddr;
    ex_branch_flag_i  = v.br;
    ex_branch_addr_i  = v.baddr;
    stalled_i         = v.stall;
    fif.fetch_ready_i = v.ready;
    e.pc = v.e_pc; e.val = v.e_val; e.pend = v.e_pend; e.mis = v.e_mis; e.idx = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk("pc",       g.idx, fif.pc_o,                   g.pc);
      chk("valid",    g.idx, {31'd0, fif.fetch_valid_o}, {31'd0, g.val});
      chk("pend",     g.idx, {31'd0, redirect_pend_o},   {31'd0, g.pend});
      chk("misalign", g.idx, {31'd0, misalign_o},        {31'd0, g.mis});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    trap_flag_i = 1'b0; trap_addr_i = '0;
    ex_branch_flag_i = 1'b0; ex_branch_addr_i = '0;
    stalled_i = 1'b0; fif.fetch_ready_i = 1'b0;

    //  trap taddr         br baddr         st rdy  e_pc          val pend mis
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0000, 1, 0, 0); // BOOT -> RUN
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0004, 1, 0, 0);
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0008, 1, 0, 0);
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_000C, 1, 0, 0);
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0010, 1, 0, 0);
    add(0, 32'h0,        1, 32'h200,      0, 0,   32'h0000_0010, 1, 1, 0); // branch, not accepted
    add(0, 32'h0,        0, 32'h0,        0, 0,   32'h0000_0010, 1, 1, 0);
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0200, 1, 0, 0); // pending applied
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0204, 1, 0, 0);
    add(1, 32'h100,      1, 32'h200,      0, 1,   32'h0000_0100, 1, 0, 0); // trap beats branch
    add(0, 32'h0,        0, 32'h0,        1, 1,   32'h0000_0100, 1, 0, 0); // stall holds
    add(0, 32'h0,        0, 32'h0,        1, 1,   32'h0000_0100, 1, 0, 0);
    add(0, 32'h0,        0, 32'h0,        1, 1,   32'h0000_0100, 1, 0, 0);
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0104, 1, 0, 0);
    add(0, 32'h0,        1, 32'h203,      0, 1,   32'h0000_0200, 1, 0, 1); // misaligned target
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0204, 1, 0, 0); // pulse is one cycle
    add(0, 32'h0,        1, 32'h3FFC,     0, 1,   32'h0000_3FFC, 1, 0, 0);
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0000, 1, 0, 0); // wrap at END_ADDR
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0004, 1, 0, 0);
    add(0, 32'h0,        1, 32'h300,      0, 0,   32'h0000_0004, 1, 1, 0);
    add(1, 32'h501,      1, 32'h600,      0, 0,   32'h0000_0004, 1, 1, 1); // newer redirect wins
    add(0, 32'h0,        0, 32'h0,        1, 1,   32'h0000_0500, 1, 0, 0); // applied despite stall
    add(0, 32'h0,        1, 32'h8000,     0, 1,   32'h0000_8000, 1, 0, 0); // outside window accepted
    add(0, 32'h0,        0, 32'h0,        0, 1,   32'h0000_0000, 1, 0, 0); // advance from beyond END wraps
    add(0, 32'h0,        0, 32'h0,        0, 0,   32'h0000_0000, 1, 0, 0); // no ready: hold
    add(0, 32'h0,        1, 32'h40,       1, 0,   32'h0000_0000, 1, 1, 0); // redirect under stall buffered

    #2;
    chk("rst_pc",    -1, fif.pc_o,                   32'h0);
    chk("rst_valid", -1, {31'd0, fif.fetch_valid_o}, 32'd0);
    chk("rst_pend",  -1, {31'd0, redirect_pend_o},   32'd0);
    chk("rst_mis",   -1, {31'd0, misalign_o},        32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Asynchronous reset while a redirect is buffered
    rst_n = 1'b0;
    #1;
    chk("async_pc",    100, fif.pc_o,                   32'h0);
    chk("async_valid", 100, {31'd0, fif.fetch_valid_o}, 32'd0);
    chk("async_pend",  100, {31'd0, redirect_pend_o},   32'd0);
    @(negedge clk);
    @(negedge clk);

    // Redirect seen in the boot cycle loads the aligned target directly
    begin
      vec_t v;
      rst_n = 1'b1;
      v.trap = 0; v.taddr = '0; v.br = 1; v.baddr = 32'h82; v.stall = 0; v.ready = 1;
      v.e_pc = 32'h80; v.e_val = 1; v.e_pend = 0; v.e_mis = 1;
      step(v, 200);
      v.br = 0; v.baddr = '0;
      v.e_pc = 32'h84; v.e_mis = 0;
      step(v, 201);
    end

    if (sb.size() != 0) chk("scoreboard_left", 300, sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
